// File: rtl/ucsbece152a_quad_decoder.sv
// Quadrature decoder: synchronizes and debounces encoder channels A/B, then
// classifies each filtered Gray-code transition into an up/down step pulse or
// a sticky illegal-transition error.
module ucsbece152a_quad_decoder #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       clr_err_i,
    output logic       step_o,
    output logic       dir_o,
    output logic       err_o,
    output logic [1:0] state_o
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NUM_CH  = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [1:0]       init_cnt_q;
    logic [1:0]       init_cnt_d;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       filt;
    logic [1:0]       prev;
    logic [CNT_W-1:0] cnt [NUM_CH];

    logic [1:0]       delta;
    logic             single_c;
    logic             illegal_c;
    logic             fwd_c;
    logic             run;

    assign run     = (state_q == RUN);
    assign state_o = filt;

    // Two-flop synchronizer per channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {a_i, b_i};
            s2 <= s1;
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Control FSM next state: INIT lasts three edges after reset release.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == 2'd2) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Per-channel debounce; INIT loads the synchronized level directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 2'b00;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (!run) begin
            filt <= s2;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s2[i] != filt[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        filt[i] <= s2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i]  <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Previous filtered state; INIT tracks the incoming level so RUN starts with no change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 2'b00;
        end else if (!run) begin
            prev <= s2;
        end else begin
            prev <= filt;
        end
    end

    // Transition classification: forward when new A differs from old B.
    always_comb begin
        delta     = filt ^ prev;
        single_c  = (delta == 2'b01) || (delta == 2'b10);
        illegal_c = (delta == 2'b11);
        fwd_c     = filt[1] ^ prev[0];
    end

    // Registered step/direction/error outputs; a new error wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_o <= 1'b0;
            dir_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            step_o <= run && single_c;
            if (run && single_c) begin
                dir_o <= ~fwd_c;
            end
            if (run && illegal_c) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule
